// File: rtl/vco_meas_pkg.sv
// Shared types and defaults for the VCO frequency meter.
// No logic; holds the FSM state type, default constants and a saturating-increment helper.
// Backpressure: not applicable.
package vco_meas_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } meter_state_t;

    localparam int DEF_MID         = 128;
    localparam int DEF_HYST        = 8;
    localparam int DEF_GATE_CYCLES = 256;

    // Adds inc to v but never exceeds maxv; callers size maxv to their counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic        inc,
                                            input logic [31:0] maxv);
        return (inc && (v < maxv)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/vco_schmitt.sv
// Hysteresis comparator that squares the sampled VCO waveform and flags LOW->HIGH transitions.
// Latency: rising pulse is registered, one cycle after the sample that crossed the upper threshold.
// Backpressure: none; free-running on every clock.
module vco_schmitt #(
    parameter int WIDTH = 8,
    parameter int MID   = 128,
    parameter int HYST  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_v,
    output logic             o_rise
);

    localparam int HI_TH = MID + HYST;
    localparam int LO_TH = MID - HYST;

    logic r_level;
    logic r_rise;
    logic w_hi;
    logic w_lo;
    logic w_level_nxt;
    logic w_rise;

    assign w_hi   = 32'(i_v) >= 32'(HI_TH);
    assign w_lo   = 32'(i_v) <  32'(LO_TH);
    assign w_rise = !r_level && w_hi;

    always_comb begin
        w_level_nxt = r_level;
        if (!r_level && w_hi) begin
            w_level_nxt = 1'b1;
        end else if (r_level && w_lo) begin
            w_level_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_rise  <= w_rise;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/vco_freq_meter.sv
// Counts rising crossings of the VCO waveform per gate window and publishes the count as freq.
// Latency: window end -> freq_valid 1 cycle; crossing -> edge_pulse 1 cycle. FREQ_METER_PERIOD_EN adds a period output.
// Backpressure: a result arriving while freq is still unconsumed is dropped and sets sticky overrun.
module vco_freq_meter
    import vco_meas_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int MID         = DEF_MID,
    parameter int HYST        = DEF_HYST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] v_in,
    input  logic             en,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    input  logic             freq_ready,
    output logic             overrun,
    output logic             edge_pulse
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [CNT_W-1:0] period
`endif
);

    localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    meter_state_t     r_state;
    meter_state_t     w_state_nxt;
    logic [GW-1:0]    r_gate_cnt;
    logic [GW-1:0]    w_gate_nxt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [CNT_W-1:0] w_edge_nxt;
    logic [CNT_W-1:0] w_edge_inc;
    logic             w_done;
    logic             w_rise;
    logic [CNT_W-1:0] r_freq;
    logic             r_freq_valid;
    logic             r_overrun;

    vco_schmitt #(
        .WIDTH (WIDTH),
        .MID   (MID),
        .HYST  (HYST)
    ) u_schmitt (
        .clk    (clk),
        .rst    (rst),
        .i_v    (v_in),
        .o_rise (w_rise)
    );

    assign w_edge_inc = CNT_W'(sat_inc(32'(r_edge_cnt), w_rise, 32'(CNT_MAX)));

    // The final gate cycle still counts its own event and always publishes, then reloads without a gap.
    always_comb begin
        w_state_nxt = r_state;
        w_gate_nxt  = r_gate_cnt;
        w_edge_nxt  = r_edge_cnt;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_edge_nxt = '0;
                if (en) begin
                    w_state_nxt = ST_GATE;
                    w_gate_nxt  = GATE_LOAD;
                end
            end
            ST_GATE: begin
                if (r_gate_cnt == '0) begin
                    w_done     = 1'b1;
                    w_edge_nxt = '0;
                    w_gate_nxt = GATE_LOAD;
                    if (!en) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (!en) begin
                    w_state_nxt = ST_IDLE;
                    w_edge_nxt  = '0;
                end else begin
                    w_gate_nxt = r_gate_cnt - GW'(1);
                    w_edge_nxt = w_edge_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_edge_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gate_cnt <= w_gate_nxt;
            r_edge_cnt <= w_edge_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_freq       <= '0;
            r_freq_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_done) begin
            if (!r_freq_valid || freq_ready) begin
                r_freq       <= w_edge_inc;
                r_freq_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_freq_valid && freq_ready) begin
            r_freq_valid <= 1'b0;
        end
    end

    assign freq       = r_freq;
    assign freq_valid = r_freq_valid;
    assign overrun    = r_overrun;
    assign edge_pulse = w_rise;

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] r_since;
    logic [CNT_W-1:0] r_period;
    logic             r_seen;

    // r_since restarts at 1 on each event so it equals the cycle spacing when the next event lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_since  <= '0;
            r_period <= '0;
            r_seen   <= 1'b0;
        end else if (w_rise) begin
            r_since <= CNT_W'(1);
            r_seen  <= 1'b1;
            if (r_seen) begin
                r_period <= r_since;
            end
        end else begin
            r_since <= CNT_W'(sat_inc(32'(r_since), 1'b1, 32'(CNT_MAX)));
        end
    end

    assign period = r_period;
`endif

endmodule

// File: tb/tb_vco_freq_meter.sv
// Scoreboard bench for vco_freq_meter: directed waveforms, expected counts queued, monitor pops on handshake.
module tb_vco_freq_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        freq_ready = 1'b0;
    logic [7:0]  v_in = 8'd0;
    logic [15:0] freq;
    logic        freq_valid;
    logic        overrun;
    logic        edge_pulse;
`ifdef FREQ_METER_PERIOD_EN
    logic [15:0] period;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int q[$];
    int half = 4;
    bit noisy = 1'b0;
    bit hi = 1'b0;
    int ph = 0;
    int cyc = 0;
    int edge_cnt = 0;
    bit chk_iv = 1'b0;
    int last_acc = -1;

    vco_freq_meter dut (
        .clk        (clk),
        .rst        (rst),
        .v_in       (v_in),
        .en         (en),
        .freq       (freq),
        .freq_valid (freq_valid),
        .freq_ready (freq_ready),
        .overrun    (overrun),
        .edge_pulse (edge_pulse)
`ifdef FREQ_METER_PERIOD_EN
        ,
        .period     (period)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Waveform source changes on the falling edge so the DUT sees stable samples.
    always @(negedge clk) begin
        if (noisy) begin
            v_in = 8'(124 + $urandom_range(0, 8));
        end else begin
            ph++;
            if (ph >= half) begin
                ph = 0;
                hi = !hi;
            end
            v_in = hi ? 8'd255 : 8'd0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        int e;
        if (edge_pulse) edge_cnt++;
        if (rst && freq_valid && freq_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: got freq %0d, expected no result", freq);
            end else begin
                e = q.pop_front();
                check("freq", int'(freq), e);
                if (chk_iv && last_acc >= 0) check("valid_interval", cyc - last_acc, 256);
                last_acc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, q.size(), 0);
        q.delete();
    endtask

    task automatic wait_low();
        int k = 0;
        while (v_in != 8'd0 && k < 40) begin
            tick(1);
            k++;
        end
    endtask

    initial begin
        int k;
        tick(2);
        check("reset_freq", int'(freq), 0);
        check("reset_valid", int'(freq_valid), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_edge_pulse", int'(edge_pulse), 0);
`ifdef FREQ_METER_PERIOD_EN
        check("reset_period", int'(period), 0);
`endif
        rst = 1'b1;
        half = 4;
        tick(40);

        // 8-cycle square wave: 32 rising crossings per 256-cycle window, back-to-back.
        freq_ready = 1'b1;
        chk_iv = 1'b1;
        last_acc = -1;
        repeat (3) q.push_back(32);
        en = 1'b1;
        drain("square_windows", 1000);
        en = 1'b0;
        chk_iv = 1'b0;
        check("square_overrun", int'(overrun), 0);
        tick(300);
        check("square_no_extra", int'(freq_valid), 0);

        // Noise inside the hysteresis band never crosses.
        noisy = 1'b1;
        tick(5);
        edge_cnt = 0;
        q.push_back(0);
        en = 1'b1;
        drain("noise_window", 600);
        en = 1'b0;
        check("noise_edges", edge_cnt, 0);

        // Consumer stalled over two windows: first result held, second dropped.
        noisy = 1'b0;
        half = 8;
        freq_ready = 1'b0;
        tick(40);
        q.push_back(16);
        en = 1'b1;
        k = 0;
        while (!freq_valid && k < 600) begin
            @(negedge clk);
            k++;
        end
        check("ovr_first_valid", int'(freq_valid), 1);
        repeat (258) @(negedge clk);
        en = 1'b0;
        check("ovr_flag", int'(overrun), 1);
        check("ovr_freq_kept", int'(freq), 16);
        check("ovr_valid_held", int'(freq_valid), 1);
        tick(1);
        freq_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_valid_drop", int'(freq_valid), 0);
        check("ovr_sticky", int'(overrun), 1);
        check("ovr_accepted", q.size(), 0);

        // Abort mid-gate publishes nothing; a later full window is correct.
        tick(1);
        en = 1'b1;
        tick(100);
        en = 1'b0;
        tick(300);
        check("abort_no_valid", int'(freq_valid), 0);
        q.push_back(16);
        en = 1'b1;
        drain("abort_rerun", 600);
        en = 1'b0;

        // Asynchronous reset mid-gate clears everything at once.
        tick(5);
        en = 1'b1;
        tick(50);
        rst = 1'b0;
        #1;
        check("rst_freq", int'(freq), 0);
        check("rst_valid", int'(freq_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_edge_pulse", int'(edge_pulse), 0);
        tick(2);
        wait_low();
        rst = 1'b1;
        q.push_back(16);
        drain("rst_full_window", 600);
        en = 1'b0;

`ifdef FREQ_METER_PERIOD_EN
        // 10-cycle period: period stays 0 until the second crossing.
        rst = 1'b0;
        half = 5;
        tick(3);
        wait_low();
        rst = 1'b1;
        k = 0;
        @(negedge clk);
        while (!edge_pulse && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("period_first_edge", int'(edge_pulse), 1);
        @(negedge clk);
        check("period_before_second", int'(period), 0);
        k = 0;
        while (!edge_pulse && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("period_second_edge", int'(edge_pulse), 1);
        @(negedge clk);
        check("period_value", int'(period), 10);
`endif

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
